// File: rtl/vector_data_memory_pkg.sv
// Shared types and defaults for the vector data memory.
// Lane geometry, mode encoding and address wrap helper.
package dm_pkg;

  localparam int LANES     = 16;
  localparam int LANE_W    = 16;
  localparam int MEM_BYTES = 256;

  typedef logic [LANES-1:0][LANE_W-1:0] vec_t;

  typedef enum logic [3:0] {
    VB = 4'b0000,
    VH = 4'b0001,
    SB = 4'b0010,
    SH = 4'b0011
  } dm_mode_e;

  function automatic int unsigned wrap_addr(
    input logic [15:0] a,
    input int unsigned off,
    input int unsigned bytes
  );
    return (32'(a) + off) % bytes;
  endfunction

endpackage

// File: rtl/vector_data_memory_if.sv
// MEM-stage bus of the vector data memory.
// Master drives mode/address/data; slave returns RD.
interface vector_data_memory_if #(
  parameter int LANES  = 16,
  parameter int LANE_W = 16
);
  logic                         WE;
  logic                         s3;
  logic                         s2;
  logic                         s1;
  logic                         s0;
  logic [15:0]                  A;
  logic [LANES-1:0][LANE_W-1:0] WD;
  logic [LANES-1:0][LANE_W-1:0] RD;

  modport master (
    output WE, s3, s2, s1, s0, A, WD,
    input  RD
  );

  modport slave (
    input  WE, s3, s2, s1, s0, A, WD,
    output RD
  );
endinterface

// File: rtl/vector_data_memory_lane_map.sv
// Per-lane byte address map for the data memory.
// Shared by the read mux and the write loop.
module dm_lane_map
  import dm_pkg::*;
#(
  parameter int LANES     = dm_pkg::LANES,
  parameter int MEM_BYTES = dm_pkg::MEM_BYTES,
  parameter int AW        = 8
) (
  input  logic [3:0]                  mode_i,
  input  logic [15:0]                 addr_i,
  output logic [LANES-1:0][AW-1:0]    lo_o,
  output logic [LANES-1:0][AW-1:0]    hi_o,
  output logic [LANES-1:0]            vld_o,
  output logic [LANES-1:0]            hi_vld_o
);

  int unsigned n_lanes;
  logic        half;

  // Decode mode; anything unmatched (incl. X) enables no lanes.
  always_comb begin
    n_lanes = 0;
    half    = 1'b0;
    case (mode_i)
      VB: begin
        n_lanes = LANES;
        half    = 1'b0;
      end
      VH: begin
        n_lanes = LANES;
        half    = 1'b1;
      end
      SB: begin
        n_lanes = 1;
        half    = 1'b0;
      end
      SH: begin
        n_lanes = 1;
        half    = 1'b1;
      end
      default: begin
        n_lanes = 0;
        half    = 1'b0;
      end
    endcase
  end

  // Lane i covers byte A+i, or bytes A+2i/A+2i+1 in half mode.
  always_comb begin
    lo_o     = '0;
    hi_o     = '0;
    vld_o    = '0;
    hi_vld_o = '0;
    for (int i = 0; i < LANES; i++) begin
      int unsigned off;
      off         = half ? 32'(2 * i) : 32'(i);
      lo_o[i]     = AW'(wrap_addr(addr_i, off, MEM_BYTES));
      hi_o[i]     = AW'(wrap_addr(addr_i, off + 1, MEM_BYTES));
      vld_o[i]    = (32'(i) < n_lanes);
      hi_vld_o[i] = (32'(i) < n_lanes) && half;
    end
  end

endmodule

// File: rtl/vector_data_memory.sv
// Byte-addressed vector data memory for the MEM stage.
// Synchronous writes, combinational reads, async clear.
module vector_data_memory
  import dm_pkg::*;
#(
  parameter int MEM_BYTES = dm_pkg::MEM_BYTES,
  parameter int LANES     = dm_pkg::LANES,
  parameter int LANE_W    = dm_pkg::LANE_W
) (
  input  logic                 CLK,
  input  logic                 RST,
  vector_data_memory_if.slave  bus
);

  localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

  logic [MEM_BYTES-1:0][7:0] mem_q;
  logic [MEM_BYTES-1:0][7:0] mem_d;
  logic [3:0]                mode;
  logic [LANES-1:0][AW-1:0]  lo;
  logic [LANES-1:0][AW-1:0]  hi;
  logic [LANES-1:0]          vld;
  logic [LANES-1:0]          hi_vld;

  assign mode = {bus.s3, bus.s2, bus.s1, bus.s0};

  dm_lane_map #(
    .LANES     (LANES),
    .MEM_BYTES (MEM_BYTES),
    .AW        (AW)
  ) u_map (
    .mode_i   (mode),
    .addr_i   (bus.A),
    .lo_o     (lo),
    .hi_o     (hi),
    .vld_o    (vld),
    .hi_vld_o (hi_vld)
  );

  // Next array: ascending lane order so the higher lane wins overlaps.
  always_comb begin
    mem_d = mem_q;
    if (bus.WE) begin
      for (int i = 0; i < LANES; i++) begin
        if (vld[i])
          mem_d[lo[i]] = bus.WD[i][7:0];
        if (hi_vld[i])
          mem_d[hi[i]] = bus.WD[i][15:8];
      end
    end
  end

  // Byte array with asynchronous clear.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      mem_q <= '0;
    else
      mem_q <= mem_d;
  end

  // Read mux: zero-extended bytes, unused lanes zero.
  always_comb begin
    bus.RD = '0;
    for (int i = 0; i < LANES; i++) begin
      if (vld[i])
        bus.RD[i][7:0] = mem_q[lo[i]];
      if (hi_vld[i])
        bus.RD[i][15:8] = mem_q[hi[i]];
    end
  end

endmodule

// File: tb/tb_vector_data_memory.sv
// Scoreboard bench for vector_data_memory.
// Byte-array reference model feeds an expected-read queue.
module tb_vector_data_memory;
  import dm_pkg::*;

  localparam int NB = dm_pkg::MEM_BYTES;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  logic [7:0] ref_mem [NB];
  vec_t exp_q [$];

  vector_data_memory_if bus ();

  vector_data_memory dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input vec_t got, input vec_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic vec_t ref_read(input logic [3:0] m, input logic [15:0] a);
    vec_t r;
    int   n;
    int   st;
    r  = '0;
    n  = 0;
    st = 1;
    case (m)
      4'b0000: begin n = LANES; st = 1; end
      4'b0001: begin n = LANES; st = 2; end
      4'b0010: begin n = 1; st = 1; end
      4'b0011: begin n = 1; st = 2; end
      default: n = 0;
    endcase
    for (int i = 0; i < n; i++) begin
      r[i][7:0] = ref_mem[(int'(a) + st * i) % NB];
      if (st == 2)
        r[i][15:8] = ref_mem[(int'(a) + 2 * i + 1) % NB];
    end
    return r;
  endfunction

  task automatic ref_write(input logic [3:0] m, input logic [15:0] a, input vec_t wd);
    int n;
    int st;
    n  = 0;
    st = 1;
    case (m)
      4'b0000: begin n = LANES; st = 1; end
      4'b0001: begin n = LANES; st = 2; end
      4'b0010: begin n = 1; st = 1; end
      4'b0011: begin n = 1; st = 2; end
      default: n = 0;
    endcase
    for (int i = 0; i < n; i++) begin
      ref_mem[(int'(a) + st * i) % NB] = wd[i][7:0];
      if (st == 2)
        ref_mem[(int'(a) + 2 * i + 1) % NB] = wd[i][15:8];
    end
  endtask

  task automatic ref_clear();
    for (int i = 0; i < NB; i++)
      ref_mem[i] = 8'h00;
  endtask

  task automatic drive(input logic [3:0] m, input logic [15:0] a);
    {bus.s3, bus.s2, bus.s1, bus.s0} = m;
    bus.A = a;
  endtask

  task automatic do_read(input string tag, input logic [3:0] m, input logic [15:0] a);
    vec_t e;
    @(negedge clk);
    bus.WE = 1'b0;
    drive(m, a);
    exp_q.push_back(ref_read(m, a));
    #1;
    e = exp_q.pop_front();
    check(tag, bus.RD, e);
  endtask

  task automatic do_write(input string tag, input logic [3:0] m, input logic [15:0] a, input vec_t wd);
    vec_t e;
    @(negedge clk);
    drive(m, a);
    bus.WD = wd;
    bus.WE = 1'b1;
    exp_q.push_back(ref_read(m, a));
    #1;
    e = exp_q.pop_front();
    check({tag, "_old"}, bus.RD, e);
    @(posedge clk);
    ref_write(m, a, wd);
    #1;
    bus.WE = 1'b0;
  endtask

  task automatic rd_const(input string tag, input logic [3:0] m, input logic [15:0] a, input vec_t e);
    @(negedge clk);
    bus.WE = 1'b0;
    drive(m, a);
    exp_q.push_back(e);
    #1;
    check(tag, bus.RD, exp_q.pop_front());
  endtask

  vec_t wd;
  vec_t ex;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    bus.WE  = 1'b0;
    bus.WD  = '0;
    drive(4'b0001, 16'd0);
    ref_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    rd_const("reset_vh", 4'b0001, 16'd0, '0);

    wd = '0;
    wd[0] = 16'h000F;
    for (int i = 1; i < LANES; i++) wd[i] = 16'h0001;
    do_write("vb_wr", 4'b0000, 16'd0, wd);
    rd_const("vb_rd", 4'b0000, 16'd0, wd);

    for (int i = 0; i < LANES; i++) wd[i] = 16'h0102 + 16'(i);
    do_write("vh_wr", 4'b0001, 16'd8, wd);
    rd_const("vh_rd", 4'b0001, 16'd8, wd);
    ex = ref_read(4'b0000, 16'd8);
    ex[0] = 16'h0002;
    ex[1] = 16'h0001;
    rd_const("vb_rd8", 4'b0000, 16'd8, ex);
    do_read("vb_rd8_model", 4'b0000, 16'd8);

    wd = '0;
    wd[0] = 16'h00AB;
    do_write("sb_wr", 4'b0010, 16'd32, wd);
    rd_const("sb_rd32", 4'b0010, 16'd32, wd);
    ex = '0;
    ex[0] = 16'h0001;
    rd_const("sb_rd33", 4'b0010, 16'd33, ex);

    for (int i = 0; i < LANES; i++) wd[i] = 16'(i + 1);
    do_write("vh_wrap_wr", 4'b0001, 16'(NB - 4), wd);
    rd_const("vh_wrap_rd", 4'b0001, 16'(NB - 4), wd);
    ex = '0;
    ex[0] = 16'h0003;
    rd_const("wrap_b0", 4'b0010, 16'd0, ex);
    ex[0] = 16'h0010;
    rd_const("wrap_b26", 4'b0011, 16'd26, ex);

    wd = '1;
    do_write("rsv_wr", 4'b0100, 16'd0, wd);
    rd_const("rsv_rd", 4'b0100, 16'd0, '0);
    do_write("rsv8_wr", 4'b1000, 16'd4, wd);
    do_write("xmode_wr", 4'bx001, 16'd0, wd);
    do_read("after_rsv", 4'b0001, 16'(NB - 4));
    do_read("after_rsv_vb", 4'b0000, 16'd0);

    for (int k = 0; k < 24; k++) begin
      logic [3:0]  m;
      logic [15:0] a;
      m = 4'($urandom_range(0, 3));
      a = 16'($urandom);
      for (int i = 0; i < LANES; i++) wd[i] = 16'($urandom);
      do_write("rnd_wr", m, a, wd);
      m = 4'($urandom_range(0, 3));
      do_read("rnd_rd", m, a);
    end

    @(negedge clk);
    drive(4'b0001, 16'(NB - 4));
    #2 rst = 1'b1;
    ref_clear();
    #1;
    check("rst_held", bus.RD, '0);
    bus.WD = '1;
    bus.WE = 1'b1;
    @(posedge clk);
    #1;
    check("rst_we", bus.RD, '0);
    bus.WE = 1'b0;
    rst = 1'b0;
    do_read("post_rst_vh", 4'b0001, 16'(NB - 4));
    do_read("post_rst_vb", 4'b0000, 16'd0);
    rd_const("post_rst_sh", 4'b0011, 16'd26, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
